mips_wb_trace: RTL
==================

Name: mips_wb_trace

Overview:
- Debug trace buffer directly downstream of the MIPS pipeline's writeback stage.
- Captures every register-file write (destination register, write data, cycle timestamp) into a FIFO.
- Presents captured entries to a debug reader over a valid/ready interface, so program results can be checked beyond the single `resultado` word.
- Sits alongside the MEM/WB latch outputs; does not feed back into the pipeline.

Parameters:
- DEPTH, 16, number of FIFO entries; power of two, 4..256.
- TS_W, 16, timestamp counter width in bits.
- DROP_W, 8, width of the dropped-event counter.

Ports:
- clk_CPU  input  1  CPU clock; all state on rising edge.
- rst_CPU  input  1  asynchronous, active-high reset.
- trace_en  input  1  capture enable; low = ignore writeback events.
- clear  input  1  synchronous flush of FIFO, drop counter and overflow flag.
- wb_we  input  1  RegWrite from the MEM/WB latch.
- wb_addr  input  5  destination register from the MEM/WB latch.
- wb_data  input  32  writeback mux output (same word driven on `resultado`).
- rd_valid  output  1  FIFO non-empty; head entry valid.
- rd_ready  input  1  reader accepts head this cycle.
- rd_ts  output  TS_W  head entry timestamp.
- rd_addr  output  5  head entry register number.
- rd_data  output  32  head entry write data.
- count  output  $clog2(DEPTH)+1  current occupancy.
- overflow  output  1  sticky: at least one event lost since reset/clear.
- drop_cnt  output  DROP_W  lost events, saturating.

Behaviour:
Reset (rst_CPU high, async):
- All outputs are 0: rd_valid, rd_ts, rd_addr, rd_data, count, overflow, drop_cnt.
- FIFO pointers and timestamp counter are 0.
- Reset mid-stream discards all entries immediately, without waiting for a clock edge.

Timestamp:
- Free-running counter, +1 every cycle after reset.
- Wraps modulo 2^TS_W.
- Is not cleared by `clear`.
- The captured value is the counter value in the cycle the event is sampled.

Event:
- An event is `trace_en & wb_we & (wb_addr != 0)`.
- Writes to $0 are never recorded and never counted as drops.

Push:
- An event at edge N produces an entry visible on rd_valid/rd_* after edge N (1-cycle latency).

Pop:
- Handshake completes on an edge where `rd_valid & rd_ready`; the head advances.
- rd_* are first-word-fall-through: driven from the stored head with no read latency.
- rd_* hold stable while `rd_valid & !rd_ready`.
- When empty, rd_* hold their last value; readers must not rely on it.

Full:
- An event while full and no pop that cycle is dropped.
- A drop sets overflow and increments drop_cnt, saturating at 2^DROP_W-1.
- Full with a pop in the same cycle: both succeed, count is unchanged, no drop.

Empty:
- A simultaneous push and pop cannot pop, because rd_valid is 0.
- The push succeeds; count goes to 1.

Pointers:
- log2(DEPTH) bits each, wrapping naturally.
- count tracks occupancy 0..DEPTH.

clear:
- Has priority over push and pop in the same cycle.
- After the edge: count=0, rd_valid=0, overflow=0, drop_cnt=0.
- The event sampled in the clear cycle is discarded and not counted.

Optional Feature:
MIPS_WB_TRACE_CHANGE_ONLY_EN:
- Defined:
  - A 31x32 shadow register file holds the last written value per register; all shadow entries reset to 0.
  - An event is recorded only if wb_data differs from the shadow value.
  - The shadow is updated on every qualifying event, even if that event is dropped because the FIFO is full.
  - clear also zeroes the shadow.
- Undefined:
  - No shadow storage; every event is recorded.

Decomposition:
- Package mips_trace_pkg holds:
  - the entry struct trace_entry_t {ts, addr, data};
  - REG_ZERO = 5'd0;
  - REG_ADDR_W = 5 and DATA_W = 32.
- One sub-module, mips_trace_fifo: a generic synchronous FWFT FIFO of trace_entry_t with push, pop, clear, full, empty and count.
- The top holds:
  - event qualification;
  - timestamp counter;
  - drop/overflow logic;
  - the optional shadow.

Test Plan:
- Reset, then wb_we=1, addr=8, data=0x0000002A at cycle 3 -> rd_valid=1 next cycle, rd_addr=8, rd_data=0x2A, rd_ts=3, count=1.
- Write to addr=0 with data=0xFFFFFFFF, trace_en=1 -> rd_valid stays 0, drop_cnt=0.
- DEPTH=16: 17 consecutive events with rd_ready=0 -> count=16, overflow=1, drop_cnt=1. Then drain 16 -> entries return in order; the 17th is absent.
- FIFO full, with push and pop in the same cycle -> count stays 16, drop_cnt unchanged, and the new entry appears after the 15 remaining older entries.
- Assert clear and an event simultaneously while holding 5 entries -> count=0, overflow=0, no entry from the clear cycle. Then rst_CPU is pulsed mid-cycle -> all outputs 0 before the next edge.
- With MIPS_WB_TRACE_CHANGE_ONLY_EN: write r9=5, r9=5, r9=6 -> exactly two entries (5, 6). Without the macro -> three entries.

Source files
------------

// File: rtl/mips_trace_pkg.sv
// mips_trace_pkg: shared types and constants for the MIPS writeback trace buffer.
//   trace_entry_t  default FIFO entry {ts, addr, data} with a 16-bit timestamp
//   REG_ZERO       register $0, never traced
//   REG_ADDR_W     register number width
//   DATA_W         register data width
package mips_trace_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int TS_W_DEF   = 16;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [TS_W_DEF-1:0]   ts;
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } trace_entry_t;

endpackage

// File: rtl/mips_trace_fifo.sv
// mips_trace_fifo: synchronous first-word-fall-through FIFO of trace entries.
// The head entry is held in a register, so dout is valid in the same cycle
// valid is high, and it keeps its last value once the FIFO drains.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   clear         synchronous flush (priority over push/pop)
//   push, din     write request and entry; refused when full unless popping
//   pop           read request; ignored when empty
//   dout, valid   head entry and non-empty flag
//   full, count   full flag and occupancy 0..DEPTH
module mips_trace_fifo
  import mips_trace_pkg::*;
#(
  parameter int  DEPTH   = 16,
  parameter type entry_t = trace_entry_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   push,
  input  entry_t                 din,
  input  logic                   pop,
  output entry_t                 dout,
  output logic                   valid,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  entry_t             mem_r [DEPTH];
  entry_t             head_r;
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic               valid_r;

  logic               full_s;
  logic               pop_s;
  logic               push_s;
  logic [CNT_W-1:0]   count_nxt_s;
  logic [CNT_W-1:0]   remain_s;
  logic [PTR_W-1:0]   head_idx_s;
  entry_t             head_nxt_s;

  // Handshake qualification, next occupancy and next head entry.
  always_comb begin
    full_s      = (count_r == CNT_W'(DEPTH));
    pop_s       = pop & valid_r;
    push_s      = push & (~full_s | pop_s);
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1);
      default: count_nxt_s = count_r;
    endcase
    // Entries still stored after this pop decide where the next head comes from:
    // an older stored entry, the entry being pushed now, or nothing (hold).
    remain_s   = count_r - CNT_W'(pop_s);
    head_idx_s = rd_ptr_r + PTR_W'(pop_s);
    head_nxt_s = head_r;
    if (remain_s != {CNT_W{1'b0}}) begin
      head_nxt_s = mem_r[head_idx_s];
    end else if (push_s) begin
      head_nxt_s = din;
    end else begin
      head_nxt_s = head_r;
    end
  end

  // Entry storage; no reset needed since reads are gated by occupancy.
  always_ff @(posedge clk) begin
    if (push_s && !clear) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers, occupancy and the registered head entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      valid_r  <= 1'b0;
      head_r   <= '0;
    end else if (clear) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      valid_r  <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r <= count_nxt_s;
      valid_r <= (count_nxt_s != {CNT_W{1'b0}});
      head_r  <= head_nxt_s;
    end
  end

  assign dout  = head_r;
  assign valid = valid_r;
  assign full  = full_s;
  assign count = count_r;

endmodule

// File: rtl/mips_wb_trace.sv
// mips_wb_trace: debug trace buffer behind the MIPS writeback stage.
// Every register-file write (except to $0) is timestamped and queued for a
// debug reader on a valid/ready interface. Events arriving while the FIFO is
// full and not being popped are lost and counted.
// Optional build macro MIPS_WB_TRACE_CHANGE_ONLY_EN: keep a shadow copy of the
// register file and record a write only when it changes the register value.
// Ports:
//   clk_CPU, rst_CPU        clock, asynchronous active-high reset
//   trace_en, clear         capture enable, synchronous flush
//   wb_we, wb_addr, wb_data writeback write enable, register, data
//   rd_valid, rd_ready      reader handshake
//   rd_ts, rd_addr, rd_data head entry
//   count                   occupancy
//   overflow, drop_cnt      sticky loss flag, saturating loss counter
module mips_wb_trace
  import mips_trace_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int TS_W   = 16,
  parameter int DROP_W = 8
) (
  input  logic                   clk_CPU,
  input  logic                   rst_CPU,
  input  logic                   trace_en,
  input  logic                   clear,
  input  logic                   wb_we,
  input  logic [REG_ADDR_W-1:0]  wb_addr,
  input  logic [DATA_W-1:0]      wb_data,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [TS_W-1:0]        rd_ts,
  output logic [REG_ADDR_W-1:0]  rd_addr,
  output logic [DATA_W-1:0]      rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic [DROP_W-1:0]      drop_cnt
);

  typedef struct packed {
    logic [TS_W-1:0]       ts;
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } entry_t;

  logic [TS_W-1:0]   ts_r;
  logic              overflow_r;
  logic [DROP_W-1:0] drop_cnt_r;

  logic              wr_evt_s;
  logic              evt_s;
  logic              full_s;
  logic              valid_s;
  logic              drop_s;
  entry_t            din_s;
  entry_t            head_s;

  assign wr_evt_s = trace_en & wb_we & (wb_addr != REG_ZERO);

`ifdef MIPS_WB_TRACE_CHANGE_ONLY_EN
  logic [DATA_W-1:0] shadow_r [31:1];
  logic [DATA_W-1:0] shadow_val_s;

  // Last written value of the addressed register ($0 has no shadow entry).
  always_comb begin
    shadow_val_s = {DATA_W{1'b0}};
    if (wb_addr != REG_ZERO) begin
      shadow_val_s = shadow_r[wb_addr];
    end else begin
      shadow_val_s = {DATA_W{1'b0}};
    end
  end

  // Shadow tracks every write, including ones the FIFO later drops.
  always_ff @(posedge clk_CPU or posedge rst_CPU) begin
    if (rst_CPU) begin
      for (int i = 1; i < 32; i++) begin
        shadow_r[i] <= {DATA_W{1'b0}};
      end
    end else if (clear) begin
      for (int i = 1; i < 32; i++) begin
        shadow_r[i] <= {DATA_W{1'b0}};
      end
    end else if (wr_evt_s) begin
      shadow_r[wb_addr] <= wb_data;
    end
  end

  assign evt_s = wr_evt_s & (wb_data != shadow_val_s);
`else
  assign evt_s = wr_evt_s;
`endif

  // A drop needs the FIFO full and no pop freeing a slot; when full, rd_valid
  // is necessarily high, so rd_ready alone decides whether a pop happens.
  assign drop_s = evt_s & full_s & ~rd_ready;

  assign din_s.ts   = ts_r;
  assign din_s.addr = wb_addr;
  assign din_s.data = wb_data;

  // Free-running timestamp, deliberately untouched by clear.
  always_ff @(posedge clk_CPU or posedge rst_CPU) begin
    if (rst_CPU) begin
      ts_r <= {TS_W{1'b0}};
    end else begin
      ts_r <= ts_r + TS_W'(1);
    end
  end

  // Sticky overflow flag and saturating drop counter.
  always_ff @(posedge clk_CPU or posedge rst_CPU) begin
    if (rst_CPU) begin
      overflow_r <= 1'b0;
      drop_cnt_r <= {DROP_W{1'b0}};
    end else if (clear) begin
      overflow_r <= 1'b0;
      drop_cnt_r <= {DROP_W{1'b0}};
    end else if (drop_s) begin
      overflow_r <= 1'b1;
      if (drop_cnt_r != {DROP_W{1'b1}}) begin
        drop_cnt_r <= drop_cnt_r + DROP_W'(1);
      end
    end
  end

  mips_trace_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk   (clk_CPU),
    .rst   (rst_CPU),
    .clear (clear),
    .push  (evt_s),
    .din   (din_s),
    .pop   (rd_ready),
    .dout  (head_s),
    .valid (valid_s),
    .full  (full_s),
    .count (count)
  );

  assign rd_valid = valid_s;
  assign rd_ts    = head_s.ts;
  assign rd_addr  = head_s.addr;
  assign rd_data  = head_s.data;
  assign overflow = overflow_r;
  assign drop_cnt = drop_cnt_r;

endmodule
